sram_1rw_fifo_ctrl: RTL and testbench



---
 rtl/sram_1rw_fifo_ctrl_pkg.sv | 22 ++
 rtl/sram_1rw_fifo_ctrl_if.sv | 22 ++
 rtl/sram_1rw_fifo_ctrl_obuf.sv | 55 +++++
 rtl/sram_1rw_fifo_ctrl.sv | 117 +++++++++++
 tb/tb_sram_1rw_fifo_ctrl.sv | 282 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sram_1rw_fifo_ctrl_pkg.sv
// Shared constants and types for the 1RW-SRAM-backed valid/ready FIFO controller.
// Default geometry matches the 8x512 single-port SRAM macro.
package sram_1rw_fifo_ctrl_pkg;

    function automatic int unsigned count_width(input int unsigned els);
        return $clog2(els + 1);
    endfunction

    localparam int unsigned obuf_els_lp        = 3;
    localparam int unsigned obuf_cnt_width_lp  = count_width(obuf_els_lp);

    localparam int unsigned sram_bits_lp       = 8;
    localparam int unsigned sram_words_lp      = 512;
    localparam int unsigned sram_addr_width_lp = 9;

    typedef enum logic [1:0] {
        sram_idle,
        sram_read,
        sram_write
    } sram_op_e;

endpackage

// File: rtl/sram_1rw_fifo_ctrl_if.sv
// Enqueue/dequeue valid-ready handshake bundle of the SRAM FIFO controller.
// master = producer/consumer side, slave = the controller.
interface sram_1rw_fifo_ctrl_if #(
    parameter int unsigned width_p = 8
);
    logic [width_p-1:0] data_i;
    logic               v_i;
    logic               ready_o;
    logic [width_p-1:0] data_o;
    logic               v_o;
    logic               ready_i;

    modport master (
        output data_i, v_i, ready_i,
        input  ready_o, data_o, v_o
    );

    modport slave (
        input  data_i, v_i, ready_i,
        output ready_o, data_o, v_o
    );
endinterface

// File: rtl/sram_1rw_fifo_ctrl_obuf.sv
// Small register FIFO holding words already read out of the SRAM.
// Circular buffer; caller guarantees no push when full and no pop when empty.
module sram_fifo_obuf
    import sram_1rw_fifo_ctrl_pkg::*;
#(
    parameter int unsigned width_p = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         push,
    input  logic [width_p-1:0]           push_data,
    input  logic                         pop,
    output logic [width_p-1:0]           data,
    output logic [obuf_cnt_width_lp-1:0] count
);

    typedef logic [1:0] idx_t;

    logic [width_p-1:0] mem [obuf_els_lp];
    idx_t               head;
    idx_t               tail;

    function automatic idx_t idx_next(input idx_t idx);
        return (idx == idx_t'(obuf_els_lp - 1)) ? '0 : idx + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (push) begin
            mem[tail] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                tail <= idx_next(tail);
            end
            if (pop) begin
                head <= idx_next(head);
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign data = mem[head];

endmodule

// File: rtl/sram_1rw_fifo_ctrl.sv
// FIFO controller that turns a single-port 1RW SRAM into a valid/ready queue,
// with a 3-entry output buffer absorbing the SRAM's one-cycle read latency.
module sram_1rw_fifo_ctrl
    import sram_1rw_fifo_ctrl_pkg::*;
#(
    parameter int unsigned width_p      = sram_bits_lp,
    parameter int unsigned els_p        = sram_words_lp,
    parameter int unsigned addr_width_p = sram_addr_width_lp
) (
    input  logic                    clk,
    input  logic                    reset,
    sram_1rw_fifo_ctrl_if.slave     fifo,
    output logic [addr_width_p-1:0] sram_addr_o,
    output logic                    sram_ce_o,
    output logic                    sram_we_o,
    output logic [width_p-1:0]      sram_wd_o,
    output logic [width_p-1:0]      sram_w_mask_o,
    input  logic [width_p-1:0]      sram_rd_i
);

    localparam int unsigned mem_cnt_width_lp = count_width(els_p);
    localparam int unsigned claim_width_lp   = obuf_cnt_width_lp + 1;

    typedef logic [addr_width_p-1:0]     addr_t;
    typedef logic [mem_cnt_width_lp-1:0] mem_cnt_t;
    typedef logic [claim_width_lp-1:0]   claim_t;

    addr_t                        wr_ptr;
    addr_t                        rd_ptr;
    mem_cnt_t                     mem_count;
    logic                         rd_pending;
    logic [obuf_cnt_width_lp-1:0] obuf_count;
    claim_t                       obuf_claim;
    logic                         read_issue;
    logic                         write_fire;
    logic                         ready;
    logic                         deq;
    sram_op_e                     op;

    function automatic addr_t ptr_next(input addr_t p);
        return (p == addr_t'(els_p - 1)) ? '0 : p + 1'b1;
    endfunction

    // Slots already owned in the output buffer, including a read still in flight.
    assign obuf_claim = claim_t'(obuf_count) + claim_t'(rd_pending);

    always_comb begin
        read_issue = 1'b0;
        ready      = 1'b0;
        write_fire = 1'b0;
        op         = sram_idle;
        if (!reset) begin
            read_issue = (mem_count != '0) && (obuf_claim < claim_t'(obuf_els_lp));
            ready      = (mem_count < mem_cnt_t'(els_p)) && !read_issue;
            write_fire = fifo.v_i && ready;
        end
        if (read_issue) begin
            op = sram_read;
        end else if (write_fire) begin
            op = sram_write;
        end
    end

    always_comb begin
        sram_addr_o = '0;
        case (op)
            sram_read:  sram_addr_o = rd_ptr;
            sram_write: sram_addr_o = wr_ptr;
            default:    sram_addr_o = '0;
        endcase
    end

    assign sram_ce_o     = (op != sram_idle);
    assign sram_we_o     = (op == sram_write);
    assign sram_wd_o     = fifo.data_i;
    assign sram_w_mask_o = '1;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            mem_count  <= '0;
            rd_pending <= 1'b0;
        end else begin
            rd_pending <= read_issue;
            if (write_fire) begin
                wr_ptr <= ptr_next(wr_ptr);
            end
            if (read_issue) begin
                rd_ptr <= ptr_next(rd_ptr);
            end
            case ({write_fire, read_issue})
                2'b10:   mem_count <= mem_count + 1'b1;
                2'b01:   mem_count <= mem_count - 1'b1;
                default: mem_count <= mem_count;
            endcase
        end
    end

    assign deq = fifo.v_o && fifo.ready_i;

    sram_fifo_obuf #(
        .width_p(width_p)
    ) obuf (
        .clk      (clk),
        .reset    (reset),
        .push     (rd_pending),
        .push_data(sram_rd_i),
        .pop      (deq),
        .data     (fifo.data_o),
        .count    (obuf_count)
    );

    assign fifo.v_o     = (obuf_count != '0);
    assign fifo.ready_o = ready;

endmodule

// File: tb/tb_sram_1rw_fifo_ctrl.sv
// Randomized scoreboard bench for sram_1rw_fifo_ctrl with a behavioural SRAM model.
module tb_sram_1rw_fifo_ctrl;

    localparam int W   = 8;
    localparam int ELS = 512;
    localparam int AW  = 9;

    logic          clk = 1'b0;
    logic          reset;
    logic [AW-1:0] sram_addr;
    logic          sram_ce;
    logic          sram_we;
    logic [W-1:0]  sram_wd;
    logic [W-1:0]  sram_w_mask;
    logic [W-1:0]  sram_rd;

    sram_1rw_fifo_ctrl_if #(.width_p(W)) fifo ();

    sram_1rw_fifo_ctrl #(
        .width_p     (W),
        .els_p       (ELS),
        .addr_width_p(AW)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .fifo         (fifo),
        .sram_addr_o  (sram_addr),
        .sram_ce_o    (sram_ce),
        .sram_we_o    (sram_we),
        .sram_wd_o    (sram_wd),
        .sram_w_mask_o(sram_w_mask),
        .sram_rd_i    (sram_rd)
    );

    always #5 clk = ~clk;

    logic [W-1:0] sram_mem [ELS];
    always @(posedge clk) begin
        if (sram_ce) begin
            if (sram_we) sram_mem[sram_addr] <= sram_wd;
            else         sram_rd <= sram_mem[sram_addr];
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: accepted words in order, plus write/read sequence numbers
    // from which the expected SRAM addresses follow as index mod depth.
    logic [W-1:0] exp_q[$];
    int           popped   = 0;
    int           wr_n     = 0;
    int           rd_n     = 0;
    int           last_wa  = -1;
    int           last_ra  = -1;
    bit           wr_wrap  = 0;
    bit           rd_wrap  = 0;

    always @(negedge clk) begin
        if (!reset && fifo.v_i && fifo.ready_o) exp_q.push_back(fifo.data_i);
    end

    always @(negedge clk) begin
        if (reset) begin
            exp_q.delete();
            wr_n = 0;
            rd_n = 0;
        end else begin
            if (fifo.v_o && fifo.ready_i) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_output", {24'd0, fifo.data_o}, 32'hFFFF_FFFF);
                end else begin
                    chk("data_o", {24'd0, fifo.data_o}, {24'd0, exp_q.pop_front()});
                end
                popped++;
            end
            if (fifo.v_i && fifo.ready_o) begin
                chk("write_we", {31'd0, sram_we}, 32'd1);
                chk("write_addr", {23'd0, sram_addr}, wr_n % ELS);
                chk("write_wd", {24'd0, sram_wd}, {24'd0, fifo.data_i});
                if (last_wa == ELS - 1 && sram_addr == '0) wr_wrap = 1;
                last_wa = int'(sram_addr);
                wr_n++;
            end else if (sram_ce) begin
                chk("read_we", {31'd0, sram_we}, 32'd0);
                chk("read_addr", {23'd0, sram_addr}, rd_n % ELS);
                chk("ready_during_read", {31'd0, fifo.ready_o}, 32'd0);
                if (last_ra == ELS - 1 && sram_addr == '0) rd_wrap = 1;
                last_ra = int'(sram_addr);
                rd_n++;
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string name, input int limit);
        int n;
        n = 0;
        fifo.v_i     = 1'b0;
        fifo.ready_i = 1'b1;
        while ((exp_q.size() != 0 || fifo.v_o) && n < limit) begin
            cyc();
            n++;
        end
        chk(name, n < limit, 1);
    endtask

    initial begin
        int  idx;
        int  n;
        int  p0;
        bit  seen;

        reset        = 1'b1;
        fifo.v_i     = 1'b0;
        fifo.data_i  = '0;
        fifo.ready_i = 1'b0;

        // Reset: two cycles, then first cycle out of reset.
        @(negedge clk);
        chk("rst_ready", {31'd0, fifo.ready_o}, 0);
        chk("rst_ce", {31'd0, sram_ce}, 0);
        chk("rst_we", {31'd0, sram_we}, 0);
        chk("rst_addr", {23'd0, sram_addr}, 0);
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("post_rst_v", {31'd0, fifo.v_o}, 0);
        chk("post_rst_ready", {31'd0, fifo.ready_o}, 1);
        chk("post_rst_ce", {31'd0, sram_ce}, 0);
        chk("post_rst_addr", {23'd0, sram_addr}, 0);
        chk("w_mask", {24'd0, sram_w_mask}, 32'hFF);

        // Single word latency: write N, read N+1, visible N+3.
        cyc();
        fifo.v_i = 1'b1; fifo.data_i = 8'hA5; fifo.ready_i = 1'b1;
        @(negedge clk);
        chk("c0_ce", {31'd0, sram_ce}, 1);
        chk("c0_we", {31'd0, sram_we}, 1);
        chk("c0_addr", {23'd0, sram_addr}, 0);
        cyc();
        fifo.v_i = 1'b0;
        @(negedge clk);
        chk("c1_ce", {31'd0, sram_ce}, 1);
        chk("c1_we", {31'd0, sram_we}, 0);
        chk("c1_addr", {23'd0, sram_addr}, 0);
        chk("c1_v", {31'd0, fifo.v_o}, 0);
        cyc();
        @(negedge clk);
        chk("c2_v", {31'd0, fifo.v_o}, 0);
        cyc();
        @(negedge clk);
        chk("c3_v", {31'd0, fifo.v_o}, 1);
        chk("c3_data", {24'd0, fifo.data_o}, 32'hA5);
        cyc();
        @(negedge clk);
        chk("c4_v", {31'd0, fifo.v_o}, 0);

        // Fill with consumer stalled: capacity is depth + 3.
        fifo.ready_i = 1'b0;
        idx = 0;
        seen = 0;
        for (int c = 0; c < 800; c++) begin
            cyc();
            fifo.v_i = 1'b1;
            fifo.data_i = idx[7:0];
            @(negedge clk);
            if (fifo.ready_o) begin
                if (idx >= ELS + 3) seen = 1;
                idx++;
            end
        end
        chk("fill_accepted", idx, ELS + 3);
        chk("fill_ready_reopened", {31'd0, seen}, 0);
        chk("fill_ready_low", {31'd0, fifo.ready_o}, 0);

        // One dequeue frees SRAM space once the refill read has been issued.
        cyc();
        fifo.v_i = 1'b0;
        fifo.ready_i = 1'b1;
        cyc();
        fifo.ready_i = 1'b0;
        seen = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (fifo.ready_o) seen = 1;
            cyc();
        end
        chk("ready_after_free", {31'd0, seen}, 1);
        p0 = popped;
        drain("fill_drain_timeout", 3000);
        chk("fill_drain_count", popped - p0, ELS + 2);

        // Random stream across pointer wrap.
        wr_wrap = 0;
        rd_wrap = 0;
        p0 = popped;
        idx = 0;
        n = 0;
        while (idx < 1500 && n < 20000) begin
            cyc();
            fifo.v_i = ($urandom_range(0, 3) != 0);
            fifo.data_i = W'($urandom);
            fifo.ready_i = $urandom_range(0, 1) == 1;
            @(negedge clk);
            if (fifo.v_i && fifo.ready_o) idx++;
            n++;
        end
        chk("stream_accepted", idx, 1500);
        cyc();
        drain("stream_drain_timeout", 3000);
        chk("stream_count", popped - p0, 1500);
        chk("write_wrap_seen", {31'd0, wr_wrap}, 1);
        chk("read_wrap_seen", {31'd0, rd_wrap}, 1);

        // Mid-operation reset with a read in flight.
        fifo.ready_i = 1'b0;
        idx = 0;
        n = 0;
        while (idx < 10 && n < 200) begin
            cyc();
            fifo.v_i = 1'b1;
            fifo.data_i = W'(8'h80 + idx);
            @(negedge clk);
            if (fifo.ready_o) idx++;
            n++;
        end
        chk("mid_accepted", idx, 10);
        cyc();
        fifo.v_i = 1'b0;
        repeat (5) cyc();
        fifo.ready_i = 1'b1;
        cyc();
        cyc();
        fifo.ready_i = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        chk("mid_rst_ce", {31'd0, sram_ce}, 0);
        chk("mid_rst_ready", {31'd0, fifo.ready_o}, 0);
        cyc();
        reset = 1'b0;
        seen = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (fifo.v_o) seen = 1;
            cyc();
        end
        chk("mid_no_stale", {31'd0, seen}, 0);
        fifo.v_i = 1'b1;
        fifo.data_i = 8'h3C;
        @(negedge clk);
        chk("mid_ready", {31'd0, fifo.ready_o}, 1);
        cyc();
        fifo.v_i = 1'b0;
        n = 0;
        while (!fifo.v_o && n < 10) begin
            cyc();
            n++;
        end
        chk("mid_v_timeout", n < 10, 1);
        @(negedge clk);
        chk("mid_first_data", {24'd0, fifo.data_o}, 32'h3C);
        cyc();
        drain("mid_drain_timeout", 50);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
